// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and STATUS field layout.
package intr_ctrl_pkg;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_EDGE    = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    localparam int unsigned STATUS_REQ_BIT   = 0;
    localparam int unsigned STATUS_INSVC_BIT = 1;
    localparam int unsigned STATUS_CAUSE_LSB = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder for the interrupt request vector.
module irq_prio_enc #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 5
) (
    input  logic [N_SRC-1:0] req_vec,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        id = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign valid = |req_vec;

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: synchronises, latches and masks N_SRC lines,
// arbitrates by fixed priority and runs the CPU intr/inta/eoi handshake.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [N_SRC-1:0] irq_src,
    output logic             intr,
    input  logic             inta,
    output logic [ID_W-1:0]  cause,
    input  logic             eoi,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata
);

    logic [N_SRC-1:0] s1_q, s2_q, prev_q;
    logic [N_SRC-1:0] enable_q, edge_q, pending_q, pending_d;
    logic [N_SRC-1:0] req_vec, cause_oh, ack_clr, w1c_clr, rise;
    logic [ID_W-1:0]  win_id, cause_q;
    logic             win_valid, intr_q;
    state_e           state_q;

    assign req_vec  = pending_q & enable_q;
    assign cause_oh = N_SRC'(1) << cause_q;
    assign rise     = s2_q & ~prev_q;
    assign ack_clr  = (state_q == StReq && inta) ? cause_oh : '0;
    assign w1c_clr  = (cfg_we && cfg_addr == ADDR_PENDING) ? cfg_wdata[N_SRC-1:0] : '0;

    // Edge sources: a new edge wins over any clear in the same cycle.
    assign pending_d = (edge_q & (rise | (pending_q & ~(ack_clr | w1c_clr))))
                     | (~edge_q & s2_q);

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_vec (req_vec),
        .id      (win_id),
        .valid   (win_valid)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            pending_q <= '0;
        end else begin
            s1_q      <= irq_src;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            pending_q <= pending_d;
            if (cfg_we && cfg_addr == ADDR_ENABLE) begin
                enable_q <= cfg_wdata[N_SRC-1:0];
            end
            if (cfg_we && cfg_addr == ADDR_EDGE) begin
                edge_q <= cfg_wdata[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            intr_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q <= StReq;
                        intr_q  <= 1'b1;
                        cause_q <= win_id;
                    end
                end
                StReq: begin
                    // Acknowledge beats withdrawal; cause stays frozen until one happens.
                    if (inta) begin
                        state_q <= StService;
                        intr_q  <= 1'b0;
                    end else if (!(|(req_vec & cause_oh))) begin
                        state_q <= StIdle;
                        intr_q  <= 1'b0;
                    end
                end
                StService: begin
                    if (eoi) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intr  = intr_q;
    assign cause = cause_q;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata[N_SRC-1:0] = enable_q;
            ADDR_EDGE:    cfg_rdata[N_SRC-1:0] = edge_q;
            ADDR_PENDING: cfg_rdata[N_SRC-1:0] = pending_q;
            ADDR_STATUS: begin
                cfg_rdata[STATUS_REQ_BIT]             = (state_q == StReq);
                cfg_rdata[STATUS_INSVC_BIT]           = (state_q == StService);
                cfg_rdata[STATUS_CAUSE_LSB +: ID_W]   = cause_q;
            end
            default: cfg_rdata = '0;
        endcase
    end

endmodule
